mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 56 +++++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the three buses that meet at the memory arbiter:
//   instr_* : instruction-fetch port (request/address in, grant/rvalid/rdata out)
//   data_*  : load/store port (request/we/be/address/wdata in,
//             grant/rvalid/rdata out)
//   mem_*   : single-port RAM side (strobe/we/be/address/wdata out,
//             read data in, valid one cycle after a read strobe)
// Modports:
//   slave  : the arbiter's view (drives grants, responses and mem_* strobes)
//   master : the surrounding system's view (core requesters plus RAM)
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
  // instruction-fetch port
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;

  // load/store port
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;

  // single-port RAM side
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port RAM between an instruction-fetch port and a
// load/store port. Data accesses normally win; after STARVE_LIMIT consecutive
// data grants made while a fetch was waiting, the fetch wins once.
// Grants and RAM strobes are combinational in the request cycle; the read
// data (or store acknowledge) is returned exactly one cycle later.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : mem_arbiter_if.slave (instr_*, data_*, mem_* groups)
// Parameter:
//   STARVE_LIMIT : consecutive data grants tolerated while a fetch waits
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned      CNT_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } state_e;

  state_e           state_r;
  state_e           state_next_s;
  logic [CNT_W-1:0] starve_cnt_r;
  logic [CNT_W-1:0] starve_cnt_next_s;
  logic             store_r;
  logic             instr_gnt_s;
  logic             data_gnt_s;

  // Arbitration: data has priority unless the fetch has been starved long enough.
  always_comb begin
    instr_gnt_s = 1'b0;
    data_gnt_s  = 1'b0;
    if (bus.instr_req_i && (!bus.data_req_i || (starve_cnt_r == LIMIT_C))) begin
      instr_gnt_s = 1'b1;
    end else if (bus.data_req_i) begin
      data_gnt_s = 1'b1;
    end else begin
      instr_gnt_s = 1'b0;
      data_gnt_s  = 1'b0;
    end
  end

  assign bus.instr_gnt_o = instr_gnt_s;
  assign bus.data_gnt_o  = data_gnt_s;

  // RAM strobe mux: winner's attributes, all-zero when nobody is granted.
  always_comb begin
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = 4'b0000;
    bus.mem_addr_o  = 32'h0000_0000;
    bus.mem_wdata_o = 32'h0000_0000;
    if (instr_gnt_s) begin
      bus.mem_req_o  = 1'b1;
      bus.mem_addr_o = bus.instr_addr_i;
    end else if (data_gnt_s) begin
      bus.mem_req_o   = 1'b1;
      bus.mem_we_o    = bus.data_we_i;
      // byte enables only mean something for stores
      bus.mem_be_o    = bus.data_we_i ? bus.data_be_i : 4'b0000;
      bus.mem_addr_o  = bus.data_addr_i;
      bus.mem_wdata_o = bus.data_wdata_i;
    end else begin
      bus.mem_req_o   = 1'b0;
    end
  end

  // Starvation counter next value: counts data wins over a waiting fetch, saturating.
  always_comb begin
    starve_cnt_next_s = starve_cnt_r;
    if (instr_gnt_s || !bus.instr_req_i) begin
      starve_cnt_next_s = '0;
    end else if (data_gnt_s) begin
      starve_cnt_next_s = (starve_cnt_r == LIMIT_C) ? LIMIT_C : (starve_cnt_r + CNT_W'(1));
    end else begin
      starve_cnt_next_s = starve_cnt_r;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt_r <= '0;
    end else begin
      starve_cnt_r <= starve_cnt_next_s;
    end
  end

  // Remember whether the granted data access was a store, so its response is zeroed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      store_r <= 1'b0;
    end else if (data_gnt_s) begin
      store_r <= bus.data_we_i;
    end else begin
      store_r <= store_r;
    end
  end

  // Response FSM state register; async reset drops any pending response at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Response FSM next state: a response follows every grant, back to back.
  always_comb begin
    state_next_s = IDLE;
    if (instr_gnt_s) begin
      state_next_s = RESP_I;
    end else if (data_gnt_s) begin
      state_next_s = RESP_D;
    end else begin
      state_next_s = IDLE;
    end
  end

  // Response FSM outputs: RAM read data routed to the port being answered.
  always_comb begin
    bus.instr_rvalid_o = 1'b0;
    bus.instr_rdata_o  = 32'h0000_0000;
    bus.data_rvalid_o  = 1'b0;
    bus.data_rdata_o   = 32'h0000_0000;
    case (state_r)
      RESP_I: begin
        bus.instr_rvalid_o = 1'b1;
        bus.instr_rdata_o  = bus.mem_rdata_i;
      end
      RESP_D: begin
        bus.data_rvalid_o = 1'b1;
        bus.data_rdata_o  = store_r ? 32'h0000_0000 : bus.mem_rdata_i;
      end
      default: begin
        bus.instr_rvalid_o = 1'b0;
        bus.data_rvalid_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Drives the arbiter with directed scenarios and held-until-granted random
// traffic. A small RAM model answers mem_* strobes; a reference model tracks
// how long a fetch has waited, which response is owed and the RAM contents.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int unsigned LIMIT = 4;

  logic clk_i;
  logic rst_ni;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // RAM model: cleared while reset is held at a clock edge, byte-enabled
  // writes, registered reads; garbage on the read bus when not reading.
  logic [31:0] ram [0:63];
  always @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
      bus.mem_rdata_i <= $urandom;
    end else if (bus.mem_req_o && bus.mem_we_o) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_be_o[b]) ram[bus.mem_addr_o[7:2]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
      bus.mem_rdata_i <= $urandom;
    end else if (bus.mem_req_o) begin
      bus.mem_rdata_i <= ram[bus.mem_addr_o[7:2]];
    end else begin
      bus.mem_rdata_i <= $urandom;
    end
  end

  // Reference model state
  int          n_pass;
  int          n_total;
  int          m_wait;       // data grants seen while the current fetch waited
  int          m_resp;       // 0 none, 1 fetch response owed, 2 data response owed
  logic [31:0] m_rdata;      // value the owed response must carry
  logic [31:0] shadow [0:63];
  logic        m_last_ig;
  logic        m_last_dg;
  string       last_grant;

  // One clock of checking: compare combinational and response outputs at the
  // falling edge, then advance the model across the rising edge.
  task automatic step();
    logic        e_ig, e_dg, e_mreq, e_mwe;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wd;
    logic [5:0]  idx;
    @(negedge clk_i);
    e_ig   = bus.instr_req_i && (!bus.data_req_i || m_wait >= int'(LIMIT));
    e_dg   = bus.data_req_i && !e_ig;
    e_mreq = e_ig || e_dg;
    e_mwe  = e_dg && bus.data_we_i;
    e_be   = e_mwe ? bus.data_be_i : 4'b0000;
    e_addr = e_ig ? bus.instr_addr_i : (e_dg ? bus.data_addr_i : 32'h0);
    e_wd   = e_dg ? bus.data_wdata_i : 32'h0;

    n_total++; if (bus.instr_gnt_o !== e_ig) $display("FAIL instr_gnt t=%0t got %b want %b", $time, bus.instr_gnt_o, e_ig); else n_pass++;
    n_total++; if (bus.data_gnt_o !== e_dg) $display("FAIL data_gnt t=%0t got %b want %b", $time, bus.data_gnt_o, e_dg); else n_pass++;
    n_total++; if (bus.mem_req_o !== e_mreq) $display("FAIL mem_req t=%0t got %b want %b", $time, bus.mem_req_o, e_mreq); else n_pass++;
    n_total++; if (bus.mem_we_o !== e_mwe) $display("FAIL mem_we t=%0t got %b want %b", $time, bus.mem_we_o, e_mwe); else n_pass++;
    n_total++; if (bus.mem_be_o !== e_be) $display("FAIL mem_be t=%0t got %b want %b", $time, bus.mem_be_o, e_be); else n_pass++;
    n_total++; if (bus.mem_addr_o !== e_addr) $display("FAIL mem_addr t=%0t got %h want %h", $time, bus.mem_addr_o, e_addr); else n_pass++;
    n_total++; if (bus.mem_wdata_o !== e_wd) $display("FAIL mem_wdata t=%0t got %h want %h", $time, bus.mem_wdata_o, e_wd); else n_pass++;
    n_total++; if (bus.instr_rvalid_o !== (m_resp == 1)) $display("FAIL instr_rvalid t=%0t got %b want %b", $time, bus.instr_rvalid_o, (m_resp == 1)); else n_pass++;
    n_total++; if (bus.instr_rdata_o !== ((m_resp == 1) ? m_rdata : 32'h0)) $display("FAIL instr_rdata t=%0t got %h want %h", $time, bus.instr_rdata_o, ((m_resp == 1) ? m_rdata : 32'h0)); else n_pass++;
    n_total++; if (bus.data_rvalid_o !== (m_resp == 2)) $display("FAIL data_rvalid t=%0t got %b want %b", $time, bus.data_rvalid_o, (m_resp == 2)); else n_pass++;
    n_total++; if (bus.data_rdata_o !== ((m_resp == 2) ? m_rdata : 32'h0)) $display("FAIL data_rdata t=%0t got %h want %h", $time, bus.data_rdata_o, ((m_resp == 2) ? m_rdata : 32'h0)); else n_pass++;

    last_grant = bus.instr_gnt_o ? "I" : (bus.data_gnt_o ? "D" : "-");
    m_last_ig  = e_ig;
    m_last_dg  = e_dg;

    @(posedge clk_i);
    if (!rst_ni) begin
      m_resp = 0;
      m_wait = 0;
      for (int i = 0; i < 64; i++) shadow[i] = 32'h0;
    end else begin
      idx = e_addr[7:2];
      if (e_ig) begin
        m_resp  = 1;
        m_rdata = shadow[idx];
      end else if (e_dg && bus.data_we_i) begin
        m_resp  = 2;
        m_rdata = 32'h0;
        for (int b = 0; b < 4; b++)
          if (bus.data_be_i[b]) shadow[idx][8*b +: 8] = bus.data_wdata_i[8*b +: 8];
      end else if (e_dg) begin
        m_resp  = 2;
        m_rdata = shadow[idx];
      end else begin
        m_resp = 0;
      end
      // waiting counter: grows with data wins over a pending fetch, capped
      if (e_ig || !bus.instr_req_i) m_wait = 0;
      else if (e_dg && m_wait < int'(LIMIT)) m_wait = m_wait + 1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.instr_req_i  = 1'b0;
    bus.instr_addr_i = 32'h0;
    bus.data_req_i   = 1'b0;
    bus.data_we_i    = 1'b0;
    bus.data_be_i    = 4'b0000;
    bus.data_addr_i  = 32'h0;
    bus.data_wdata_i = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    #2;
    n_total++; if (bus.instr_rvalid_o !== 1'b0 || bus.data_rvalid_o !== 1'b0) $display("FAIL reset_rvalid got %b%b want 00", bus.instr_rvalid_o, bus.data_rvalid_o); else n_pass++;
    n_total++; if (bus.instr_rdata_o !== 32'h0 || bus.data_rdata_o !== 32'h0) $display("FAIL reset_rdata got %h/%h want 0", bus.instr_rdata_o, bus.data_rdata_o); else n_pass++;
    @(posedge clk_i); #1;
    step();
    // grants still follow inputs while reset is held, but no response follows
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h0000_0020;
    step();
    step();
    // an access granted in the release cycle responds normally
    rst_ni = 1'b1;
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_single_fetch();
    // place 0x13 at 0x10 with a full-word store, then fetch it
    bus.data_req_i   = 1'b1;
    bus.data_we_i    = 1'b1;
    bus.data_be_i    = 4'b1111;
    bus.data_addr_i  = 32'h0000_0010;
    bus.data_wdata_i = 32'h0000_0013;
    step();
    idle_inputs();
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h0000_0010;
    step();
    idle_inputs();
    step();
    n_total++; if (m_rdata !== 32'h0000_0013) $display("FAIL fetch_model_value got %h want 00000013", m_rdata); else n_pass++;
  endtask

  task automatic test_starvation();
    string pat;
    idle_inputs();
    step();
    pat = "";
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h0000_0040;
    bus.data_req_i   = 1'b1;
    bus.data_we_i    = 1'b0;
    bus.data_addr_i  = 32'h0000_0080;
    for (int i = 0; i < 10; i++) begin
      step();
      pat = {pat, last_grant};
    end
    n_total++; if (pat != "DDDDIDDDDI") $display("FAIL starve_pattern got %s want DDDDIDDDDI", pat); else n_pass++;
    idle_inputs();
    step();
  endtask

  task automatic test_store_load();
    bus.data_req_i   = 1'b1;
    bus.data_we_i    = 1'b1;
    bus.data_be_i    = 4'b0011;
    bus.data_addr_i  = 32'h0000_0100;
    bus.data_wdata_i = 32'hDEAD_BEEF;
    step();
    bus.data_we_i    = 1'b0;
    bus.data_be_i    = 4'b0000;
    bus.data_wdata_i = 32'h0;
    step();
    idle_inputs();
    #1;
    n_total++; if (bus.data_rdata_o !== 32'h0000_BEEF) $display("FAIL load_after_store got %h want 0000beef", bus.data_rdata_o); else n_pass++;
    step();
  endtask

  task automatic test_reset_mid_resp();
    string pat;
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h0000_0004;
    bus.data_req_i   = 1'b1;
    bus.data_we_i    = 1'b0;
    bus.data_addr_i  = 32'h0000_0008;
    step();
    step();
    n_total++; if (bus.data_rvalid_o !== 1'b1) $display("FAIL resp_d_before_pulse got %b want 1", bus.data_rvalid_o); else n_pass++;
    rst_ni = 1'b0;
    #1;
    n_total++; if (bus.data_rvalid_o !== 1'b0) $display("FAIL rvalid_drop_on_reset got %b want 0", bus.data_rvalid_o); else n_pass++;
    n_total++; if (bus.data_rdata_o !== 32'h0) $display("FAIL rdata_drop_on_reset got %h want 0", bus.data_rdata_o); else n_pass++;
    #1;
    rst_ni = 1'b1;
    m_resp = 0;
    m_wait = 0;
    // waiting count restarted: a full LIMIT of data grants before the fetch
    pat = "";
    for (int i = 0; i < 5; i++) begin
      step();
      pat = {pat, last_grant};
    end
    n_total++; if (pat != "DDDDI") $display("FAIL starve_after_reset got %s want DDDDI", pat); else n_pass++;
    idle_inputs();
    step();
  endtask

  task automatic test_idle();
    idle_inputs();
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_random();
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      if (!bus.instr_req_i || m_last_ig || ($urandom_range(0, 15) == 0)) begin
        bus.instr_req_i  = ($urandom_range(0, 2) != 0);
        bus.instr_addr_i = {24'h0, 6'($urandom), 2'b00};
      end
      if (!bus.data_req_i || m_last_dg || ($urandom_range(0, 15) == 0)) begin
        bus.data_req_i   = ($urandom_range(0, 2) != 0);
        bus.data_we_i    = 1'($urandom);
        bus.data_be_i    = 4'($urandom);
        bus.data_addr_i  = {24'h0, 6'($urandom), 2'b00};
        bus.data_wdata_i = $urandom;
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    m_wait    = 0;
    m_resp    = 0;
    m_rdata   = 32'h0;
    m_last_ig = 1'b0;
    m_last_dg = 1'b0;
    for (int i = 0; i < 64; i++) shadow[i] = 32'h0;
    test_reset();
    test_single_fetch();
    test_starvation();
    test_store_load();
    test_reset_mid_resp();
    test_idle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
